// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Galois LFSR with seed load, zero-seed protection,
// period-wrap pulse and a flow-controlled serial snapshot port (LSB first).
module lfsr_gen #(
  parameter int               WIDTH        = 8,
  parameter logic [WIDTH-1:0] TAPS         = 8'hB8,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 8'h01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             enable,
  input  logic             out_req,
  input  logic             out_ready,
  output logic             out_bit,
  output logic             out_valid,
  output logic             out_last,
  output logic             busy,
  output logic [WIDTH-1:0] lfsr_state,
  output logic             wrap,
  output logic             zero_seed
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  // One Galois step: shift right, fold the feedback mask in when the
  // outgoing bit is set.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    return {1'b0, s[WIDTH-1:1]} ^ ({WIDTH{s[0]}} & TAPS);
  endfunction

  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] start;
  logic [WIDTH-1:0] step_nxt;
  logic [WIDTH-1:0] snap;
  logic [CW-1:0]    cnt;
  state_t           state;

  assign step_nxt   = lfsr_step(lfsr);
  assign lfsr_state = lfsr;

  // LFSR register, period start value and the wrap / zero-seed event pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr      <= DEFAULT_SEED;
      start     <= DEFAULT_SEED;
      wrap      <= 1'b0;
      zero_seed <= 1'b0;
    end else begin
      wrap      <= 1'b0;
      zero_seed <= 1'b0;
      if (load) begin
        if (seed == '0) begin
          // A zero seed would lock the register forever; substitute the default.
          lfsr      <= DEFAULT_SEED;
          start     <= DEFAULT_SEED;
          zero_seed <= 1'b1;
        end else begin
          lfsr  <= seed;
          start <= seed;
        end
      end else if (enable) begin
        lfsr <= step_nxt;
        wrap <= (step_nxt == start);
      end
    end
  end

  // Snapshot shift register: data only, so it carries no reset. It is
  // loaded from the pre-update LFSR value and shifts once per handshake.
  always_ff @(posedge clk) begin
    if (state == IDLE && out_req) begin
      snap <= lfsr;
    end else if (state == SHIFT && out_ready) begin
      snap <= snap >> 1;
    end
  end

  // Serial transfer FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      out_bit   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (out_req) begin
            state     <= SHIFT;
            cnt       <= '0;
            out_bit   <= lfsr[0];
            out_valid <= 1'b1;
            out_last  <= (LAST == '0);
            busy      <= 1'b1;
          end
        end
        SHIFT: begin
          if (out_ready) begin
            if (cnt == LAST) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
            end else begin
              cnt      <= cnt + 1'b1;
              out_bit  <= snap[1];
              out_last <= ((cnt + 1'b1) == LAST);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
